round_referee: RTL
==================

// Module: round_referee
// PURPOSE
//  Producer side of the win-event interface consumed by the score counter.
//  Samples both players' crash flags on each game tick and decides each round: P1 win, P2 win or draw.
//  Presents the result to the scoreboard with a valid/ack handshake and keeps a local match score.
//  Inserts an inter-round pause and declares the match over at WIN_SCORE.
//  Sits between the per-player movement/collision logic and the scoreboard/HEX display.
// PARAMETERS
//  SCORE_W      4   width of each player's score register
//  WIN_SCORE    5   score that ends the match; must be < 2**SCORE_W
//  PAUSE_TICKS  3   game ticks spent in PAUSE between rounds (0 allowed)
//  PAUSE_W      4   width of pause down-counter; PAUSE_TICKS < 2**PAUSE_W
// PORTS
//  clk           in   1        system clock (CLOCK_50 domain)
//  reset_n       in   1        synchronous active-low reset
//  start         in   1        level; begins a match from IDLE or OVER
//  tick          in   1        1-cycle game-step strobe from the rate divider
//  p1_crash      in   1        P1 collided this step; sampled only when tick=1
//  p2_crash      in   1        P2 collided this step; sampled only when tick=1
//  win_ack       in   1        scoreboard accepted the presented win
//  win_valid     out  1        a win is being presented
//  win_who       out  1        0 = P1 won, 1 = P2 won; stable while win_valid
//  draw          out  1        1-cycle pulse: both crashed on the same tick
//  round_active  out  1        1 in PLAY; movement logic advances only while high
//  p1_score      out  SCORE_W  P1 rounds won this match
//  p2_score      out  SCORE_W  P2 rounds won this match
//  match_over    out  1        1 in OVER
//  match_winner  out  1        0 = P1, 1 = P2; valid while match_over
// BEHAVIOUR
//  - Reset (synchronous; sampled at posedge clk with reset_n=0):
//    - state=IDLE; every output 0; pause counter 0.
//    - Mid-operation reset drops any pending win without an ack.
//  - IDLE: start=1 -> PLAY on the next edge; both scores cleared.
//  - PLAY (round_active=1). On tick=1:
//    - p1_crash only -> win_who=1, go to REPORT.
//    - p2_crash only -> win_who=0, go to REPORT.
//    - both -> draw=1 for one cycle, go to PAUSE; scores unchanged.
//    - neither -> stay in PLAY. Crash flags without tick are ignored.
//  - REPORT:
//    - win_valid=1 starting the cycle after the deciding tick (latency 1); win_who held.
//    - On win_ack=1: winner's score += 1 (saturating at 2**SCORE_W-1); win_valid=0 next cycle.
//    - Then: new score == WIN_SCORE -> OVER, else -> PAUSE.
//    - tick is ignored in REPORT; no timeout.
//  - PAUSE:
//    - Counter loads PAUSE_TICKS on entry and decrements on each tick.
//    - Exits to PLAY on the tick that sees counter==0.
//    - PAUSE_TICKS=0 -> PLAY on the next edge, tick not required.
//  - OVER: match_over=1; match_winner = side that reached WIN_SCORE.
//    - start=1 -> clear scores, go to PLAY.
//  - Ignored inputs:
//    - start in PLAY, REPORT or PAUSE.
//    - win_ack outside REPORT.
//  - Exactly one of {win_valid, draw} per round; win_valid never pulses when a draw occurs.
// STRUCTURE
//  - Shared package tron_pkg:
//    - state localparams IDLE/PLAY/REPORT/PAUSE/OVER (3-bit);
//    - PLAYER_P1=1'b0, PLAYER_P2=1'b1 (same who encoding the scoreboard uses).
//  - One sub-module, pause_timer(clk, reset_n, load, tick, done): loadable down-counter, PAUSE_W bits.
//  - Top level: FSM, two score registers, output decode.
// TESTING
//  1. reset_n=0 for 2 cycles -> all outputs 0, state IDLE;
//     start=1 -> round_active=1 next cycle.
//  2. PLAY, tick with p2_crash=1 -> next cycle win_valid=1, win_who=0;
//     hold ack low 5 cycles -> outputs stable; ack -> p1_score=1, win_valid=0.
//  3. PLAY, tick with both crashes -> draw high exactly 1 cycle, win_valid stays 0, scores 0;
//     PLAY again after 3+1 ticks.
//  4. P2 wins 5 rounds (WIN_SCORE=5) -> after 5th ack, p2_score=5, match_over=1, match_winner=1;
//     start -> scores 0, PLAY.
//  5. p1_crash=1 with tick=0 for 10 cycles -> no state change;
//     start and win_ack toggled in PLAY -> ignored.
//  6. reset_n=0 while win_valid=1 -> next cycle win_valid=0, scores 0, IDLE.

Source files
------------

// File: rtl/tron_pkg.sv
// Shared definitions for the round referee and the scoreboard it feeds.
// The player encoding here is the same "who" encoding the scoreboard consumes.
package tron_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PLAY   = 3'd1,
        REPORT = 3'd2,
        PAUSE  = 3'd3,
        OVER   = 3'd4
    } state_e;

    localparam logic PLAYER_P1 = 1'b0;
    localparam logic PLAYER_P2 = 1'b1;

endpackage

// File: rtl/pause_timer.sv
// Loadable down-counter that measures the inter-round pause in game ticks.
// done is high whenever the count has reached zero.
module pause_timer #(
    parameter int unsigned PAUSE_W     = 4,
    parameter int unsigned PAUSE_TICKS = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic tick,
    output logic done
);

    logic [PAUSE_W-1:0] count_q;
    logic [PAUSE_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = PAUSE_W'(PAUSE_TICKS);
        end else if (tick && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/round_referee.sv
// Decides each round from the crash flags, presents wins to the scoreboard over
// a valid/ack handshake, keeps the match score and paces rounds with a pause.
module round_referee
    import tron_pkg::*;
#(
    parameter int unsigned SCORE_W     = 4,
    parameter int unsigned WIN_SCORE   = 5,
    parameter int unsigned PAUSE_TICKS = 3,
    parameter int unsigned PAUSE_W     = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               tick,
    input  logic               p1_crash,
    input  logic               p2_crash,
    input  logic               win_ack,
    output logic               win_valid,
    output logic               win_who,
    output logic               draw,
    output logic               round_active,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic               match_over,
    output logic               match_winner
);

    localparam logic [SCORE_W-1:0] ScoreMax = {SCORE_W{1'b1}};
    localparam logic [SCORE_W-1:0] ScoreWin = SCORE_W'(WIN_SCORE);

    state_e             state_q, state_d;
    logic               win_who_q, win_who_d;
    logic               draw_q, draw_d;
    logic [SCORE_W-1:0] p1_score_q, p1_score_d;
    logic [SCORE_W-1:0] p2_score_q, p2_score_d;
    logic [SCORE_W-1:0] new_score;
    logic               timer_load;
    logic               timer_done;

    pause_timer #(
        .PAUSE_W    (PAUSE_W),
        .PAUSE_TICKS(PAUSE_TICKS)
    ) u_pause_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (timer_load),
        .tick   (tick && (state_q == PAUSE)),
        .done   (timer_done)
    );

    // Score the presented winner would reach once the ack lands (saturating).
    always_comb begin
        new_score = (win_who_q == PLAYER_P2) ? p2_score_q : p1_score_q;
        if (new_score != ScoreMax) begin
            new_score = new_score + 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        win_who_d  = win_who_q;
        draw_d     = 1'b0;
        p1_score_d = p1_score_q;
        p2_score_d = p2_score_q;

        unique case (state_q)
            IDLE, OVER: begin
                if (start) begin
                    p1_score_d = '0;
                    p2_score_d = '0;
                    state_d    = PLAY;
                end
            end
            PLAY: begin
                if (tick) begin
                    if (p1_crash && p2_crash) begin
                        draw_d  = 1'b1;
                        state_d = PAUSE;
                    end else if (p1_crash) begin
                        win_who_d = PLAYER_P2;
                        state_d   = REPORT;
                    end else if (p2_crash) begin
                        win_who_d = PLAYER_P1;
                        state_d   = REPORT;
                    end
                end
            end
            REPORT: begin
                if (win_ack) begin
                    if (win_who_q == PLAYER_P2) begin
                        p2_score_d = new_score;
                    end else begin
                        p1_score_d = new_score;
                    end
                    state_d = (new_score == ScoreWin) ? OVER : PAUSE;
                end
            end
            PAUSE: begin
                // A zero-length pause releases immediately without waiting for a tick.
                if (timer_done && (tick || (PAUSE_TICKS == 0))) begin
                    state_d = PLAY;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign timer_load = (state_d == PAUSE) && (state_q != PAUSE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            win_who_q  <= 1'b0;
            draw_q     <= 1'b0;
            p1_score_q <= '0;
            p2_score_q <= '0;
        end else begin
            state_q    <= state_d;
            win_who_q  <= win_who_d;
            draw_q     <= draw_d;
            p1_score_q <= p1_score_d;
            p2_score_q <= p2_score_d;
        end
    end

    assign win_valid    = (state_q == REPORT);
    assign win_who      = win_who_q;
    assign draw         = draw_q;
    assign round_active = (state_q == PLAY);
    assign p1_score     = p1_score_q;
    assign p2_score     = p2_score_q;
    assign match_over   = (state_q == OVER);
    assign match_winner = ((state_q == OVER) && (p2_score_q == ScoreWin)) ? PLAYER_P2 : PLAYER_P1;

endmodule
